// File: rtl/aes_pkg.sv
// Shared AES tables, FSM encoding and GF(2^8) helpers for the AES-128 decrypt core.
// Bytes are column-major: byte 0 sits in [127:120], byte i is row i%4 of column i/4.
package aes_pkg;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    // Index 0 and 11..15 are padding so any 4-bit round counter is a safe index.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DECRYPT = 2'd2, DONE = 2'd3} dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // rc is the constant that produced k, so the result is the previous round key.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; 'last' drops InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] keyed;

    assign keyed     = inv_sub_bytes(inv_shiftrows(state_in)) ^ round_key;
    assign state_out = last ? keyed : inv_mixcolumns(keyed);

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: forward key expansion to k10, then 10 inverse rounds with
// round keys regenerated backwards. Optional key cache: define AES_DEC_KEY_CACHE_EN.
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output dec_state_e   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and plaintext holds until taken.
    dec_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d, key_q, key_d, pt_q, pt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] fwd_key, inv_key, round_out;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] ckey_q, ckey_d, ck10_q, ck10_d;
    logic         cvld_q, cvld_d;
    logic         hit;
    assign hit = cvld_q && (key == ckey_q);
`endif

    assign fwd_key = fwd_key_step(key_q, RCON[rnd_q]);
    assign inv_key = inv_key_step(key_q, RCON[rnd_q + 4'd1]);

    aes_inv_round u_round (
        .state_in  (state_q),
        .round_key (inv_key),
        .last      (rnd_q == 4'd0),
        .state_out (round_out)
    );

    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = (fsm_q == DONE);
    assign plaintext = pt_q;
    assign dbg_state = fsm_q;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        pt_d    = pt_q;
`ifdef AES_DEC_KEY_CACHE_EN
        ckey_d  = ckey_q;
        ck10_d  = ck10_q;
        cvld_d  = cvld_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = ciphertext;
                    key_d   = key;
                    rnd_d   = 4'd1;
                    fsm_d   = EXPAND;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (hit) begin
                        state_d = ciphertext ^ ck10_q;
                        key_d   = ck10_q;
                        rnd_d   = 4'(NR - 1);
                        fsm_d   = DECRYPT;
                    end else begin
                        ckey_d = key;
                        cvld_d = 1'b0;
                    end
`endif
                end
            end
            EXPAND: begin
                key_d = fwd_key;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'(NR)) begin
                    // Initial AddRoundKey uses k10 straight off the expansion output.
                    state_d = state_q ^ fwd_key;
                    rnd_d   = 4'(NR - 1);
                    fsm_d   = DECRYPT;
`ifdef AES_DEC_KEY_CACHE_EN
                    ck10_d = fwd_key;
                    cvld_d = 1'b1;
`endif
                end
            end
            DECRYPT: begin
                key_d   = inv_key;
                state_d = round_out;
                if (rnd_q == 4'd0) begin
                    pt_d  = round_out;
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            pt_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ckey_q <= '0;
            ck10_q <= '0;
            cvld_q <= 1'b0;
        end else begin
            ckey_q <= ckey_d;
            ck10_q <= ck10_d;
            cvld_q <= cvld_d;
        end
    end
`endif

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: FIPS-197 vectors plus random blocks encrypted by a forward AES model.
module tb_aes_decrypt_core;
    import aes_pkg::*;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    dec_state_e   dbg_state;

    int           chk_cnt = 0;
    int           err_cnt = 0;
    logic [127:0] exp_q[$];
    int           exp_lat;
    logic [7:0]   sb [256];
    logic         mdl_cache_vld;
    logic [127:0] mdl_cache_key;

    aes_decrypt_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .ciphertext (ciphertext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_gf(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_gf(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = m_xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
                    s[4*c+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        key        = '0;
        ciphertext = '0;
        mdl_cache_vld = 1'b0;
        mdl_cache_key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_plaintext", plaintext, '0);
        check("rst_fsm", dbg_state, IDLE);
        rst = 1'b0;
        #1;
        check("rst_release_ready", in_ready, 1'b1);
    endtask

    // Presents one block and returns #1 after the accept edge.
    task automatic send(input logic [127:0] k, input logic [127:0] c);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_ready", in_ready, 1'b1);
`ifdef AES_DEC_KEY_CACHE_EN
        if (mdl_cache_vld && k == mdl_cache_key) begin
            exp_lat = 11;
        end else begin
            exp_lat = 21;
            mdl_cache_key = k;
            mdl_cache_vld = 1'b1;
        end
`else
        exp_lat = 21;
`endif
        key        = k;
        ciphertext = c;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        key        = rand128();
        ciphertext = rand128();
    endtask

    // skip = edges already elapsed since the accept edge; hold = cycles of out_ready low.
    task automatic collect(input int skip, input int hold, input string tag);
        int n;
        logic [127:0] exp;
        n = skip;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_latency"}, 128'(n + 1), 128'(exp_lat));
        if (!out_valid) return;
        check({tag, "_pt"}, plaintext, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_pt"}, plaintext, exp);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, out_valid, 1'b0);
        check({tag, "_back_ready"}, in_ready, 1'b1);
    endtask

    // ---------------- scenario ----------------
    initial begin
        logic [127:0] k, p, prev_k;
        build_sbox();
        do_reset();

        exp_q.push_back(C1_PT);
        send(C1_KEY, C1_CT);
        collect(0, 0, "fips_c1");

        exp_q.push_back(B_PT);
        send(B_KEY, B_CT);
        repeat (10) @(posedge clk);
        #1;
        check("fips_b_k10", dut.key_q, B_K10);
        check("fips_b_fsm", dbg_state, DECRYPT);
        collect(10, 0, "fips_b");

        k = rand128();
        p = rand128();
        exp_q.push_back(p);
        send(k, ref_encrypt(k, p));
        collect(0, 5, "backpressure");

        k = rand128();
        p = rand128();
        exp_q.push_back(p);
        send(k, ref_encrypt(k, p));
        repeat (12) @(posedge clk);
        #1;
        check("busy_in_ready", in_ready, 1'b0);
        in_valid   = 1'b1;
        key        = rand128();
        ciphertext = rand128();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(13, 0, "busy_ignore");

        send(C1_KEY, C1_CT);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_cache_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_idle_valid", out_valid, 1'b0);
            check("abort_idle_pt", plaintext, '0);
            check("abort_idle_ready", in_ready, 1'b1);
        end

        exp_q.push_back(C1_PT);
        send(C1_KEY, C1_CT);
        collect(0, 0, "after_abort_c1");
        exp_q.push_back(C1_PT);
        send(C1_KEY, C1_CT);
        collect(0, 0, "repeat_c1");
        exp_q.push_back(B_PT);
        send(B_KEY, B_CT);
        collect(0, 0, "switch_b");

        prev_k = B_KEY;
        for (int i = 0; i < 12; i++) begin
            k = ($urandom_range(0, 2) == 0) ? prev_k : rand128();
            p = rand128();
            exp_q.push_back(p);
            send(k, ref_encrypt(k, p));
            collect(0, $urandom_range(0, 3), "random");
            prev_k = k;
        end

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
- Iterative AES-128 decryption engine; the inverse counterpart of the encryption round datapath (SubBytes/ShiftRows/AddRoundKey).
- Accepts a 128-bit ciphertext and the cipher key over a valid/ready handshake.
- Expands the key forward to the round-10 key, then runs 10 inverse rounds, regenerating each round key backwards on the fly.
- Plaintext is presented on a valid/ready output; the block sits beside the encrypt core in the engine top.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, exposed only for assertions.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high; all state cleared on assertion
- in_valid  in  1  ciphertext/key valid
- in_ready  out  1  core can accept; high only in IDLE
- key  in  128  cipher key (round-0 key); byte 0 is MSB [127:120]
- ciphertext  in  128  block to decrypt; same byte order
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  128  decrypted block

Behaviour:
- Reset values: in_ready=0 while rst is high, 1 after release (IDLE); out_valid=0; plaintext=0; state reg, key reg and round counter = 0; FSM = IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready (cycle T), latch ciphertext and key; rnd<=1; go to EXPAND.
  - EXPAND (cycles T+1..T+10): key_reg <= forward_expand(key_reg, rcon[rnd]); rnd++. On rnd==10, also state <= ct ^ k10, computed combinationally from the expansion output. Then rnd<=9; go to DECRYPT.
  - DECRYPT (cycles T+11..T+20):
    - k_r = inverse_expand(key_reg, rcon[r+1]).
    - For r>=1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k_r).
    - For r==0: state <= InvSubBytes(InvShiftRows(state)) ^ k0, with no InvMixColumns.
    - key_reg <= k_r; rnd--. After r==0, plaintext <= result; go to DONE.
  - DONE: out_valid=1 from cycle T+21. plaintext is stable until the out_valid&out_ready cycle, then out_valid<=0 and FSM goes to IDLE.
- Latency accept→out_valid: 21 cycles. Minimum initiation interval: 22 cycles with out_ready tied high.
- Inputs are ignored outside IDLE. in_valid may drop without effect when in_ready=0.
- out_ready is ignored unless out_valid=1.
- rst mid-operation: immediate abort to IDLE; out_valid=0; no partial plaintext is ever exposed.
- Inverse key step: w'[i] = w[i] ^ w[i-1] for i=3..1; w'[0] = w[0] ^ SubWord(RotWord(w'[3])) ^ rcon.
- All arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are 0e/0b/0d/09.

Optional Feature:
- Macro AES_DEC_KEY_CACHE_EN.
- Defined:
  - Adds a cached cipher key, cached k10 and a cache-valid bit; cache-valid is cleared by rst.
  - On accept with cache-valid and key==cached key: skip EXPAND. State <= ct ^ cached_k10 and key_reg <= cached_k10 in the accept cycle; go straight to DECRYPT with rnd=9. out_valid at T+11.
  - On a miss: normal path; the cache is updated at the end of EXPAND.
- Undefined: no cache registers; latency is always 21.

Decomposition:
- Package aes_pkg: SBOX and INV_SBOX byte tables, RCON[1..10] (01,02,04,08,10,20,40,80,1b,36), FSM state enum (IDLE, EXPAND, DECRYPT, DONE), and functions xtime, gmul, inv_shiftrows, inv_mixcolumns.
- One sub-module: aes_inv_round (combinational; state_in, round_key, last flag → state_out), instantiated once.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff; out_valid exactly 21 cycles after accept.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. Probe key_reg at end of EXPAND = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → plaintext stable and in_ready=0 throughout; raise out_ready → out_valid drops next cycle, in_ready=1.
- Busy ignore: pulse in_valid with other data during DECRYPT → no effect; result still matches the first block.
- Assert rst at cycle T+15 → out_valid stays 0, in_ready=1 after release; the next C.1 transaction decrypts correctly.
- AES_DEC_KEY_CACHE_EN: two back-to-back C.1 blocks with the same key → second out_valid 11 cycles after accept; then a B key → 21 cycles and a correct result.
